fbuf_write_bridge: RTL and testbench
====================================

Name: fbuf_write_bridge

Overview:
Sits directly downstream of the GPU command decoder's framebuffer write port and upstream of framebuffer BRAM port A. Buffers pixel writes in a small FIFO so port A can be shared via a grant input. Executes framebuffer clear requests by draining pending writes, then sweeping every pixel address with a clear value. Drives the busy flag back to the decoder.

Parameters:
FRAME_WIDTH_SCALED, 640, pixels per line
FRAME_HEIGHT_SCALED, 480, lines per frame; NPIX = width*height
FBUF_ADDR_WIDTH, 19, BRAM address width
FBUF_DATA_WIDTH, 8, pixel width
FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 (minimum 2)
CLEAR_VALUE, 0, pixel value written during clear

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
fbuf_en_wr  in  1  write port enable from decoder
fbuf_wrea  in  1  write strobe; a write is offered when fbuf_en_wr && fbuf_wrea
fbuf_addr  in  FBUF_ADDR_WIDTH  pixel address
fbuf_data  in  FBUF_DATA_WIDTH  pixel value
fbuf_rst_req_n  in  1  active-low clear request
fbuf_rst_busy  out  1  bridge busy (clearing or FIFO near full)
bram_gnt  in  1  port A grant from arbiter
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable (equals bram_en)
bram_addr  out  FBUF_ADDR_WIDTH  BRAM address
bram_din  out  FBUF_DATA_WIDTH  BRAM write data
drop_count  out  16  dropped-write count (see Optional Feature)

Behaviour:
- Reset values: bram_en=0, bram_we=0, bram_addr=0, bram_din=0, fbuf_rst_busy=0, drop_count=0. FIFO empty, state IDLE, clear-request edge detector primed to 1.
- Reset mid-operation aborts any clear, discards FIFO contents, and returns to IDLE next cycle.
- States: IDLE, DRAIN, CLEAR.
- Clear trigger: a falling edge of fbuf_rst_req_n (registered previous value 1, current value 0) seen in IDLE moves to DRAIN. Holding it low does not retrigger. Edges seen in DRAIN or CLEAR are ignored.
- IDLE:
  - An offered write with addr < NPIX is pushed at the edge.
  - A write with addr >= NPIX is dropped.
  - A write offered when FIFO is full and no pop happens that cycle is dropped.
  - Push and pop in the same cycle at full is accepted.
- DRAIN: no pushes; offered writes are discarded silently. FIFO keeps popping. Moves to CLEAR when FIFO is empty and no pop is pending; the clear address counter is loaded to 0.
- CLEAR:
  - Each edge with bram_gnt=1 issues a write {counter, CLEAR_VALUE} and increments the counter.
  - After issuing NPIX-1, the next edge goes to IDLE.
  - Offered writes are discarded silently.
  - bram_gnt=0 stalls the counter.
- Pop/issue, IDLE and DRAIN: at each edge, if bram_gnt=1 and FIFO is non-empty, the FIFO head is registered onto bram_addr/bram_din with bram_en=bram_we=1. Otherwise bram_en=bram_we=0 and addr/din hold their last values.
- Latency: a write accepted at edge N appears on bram_* in the cycle after edge N+1 when the FIFO was empty and bram_gnt=1. Writes leave in FIFO order.
- fbuf_rst_busy is registered. It is 1 when state is DRAIN or CLEAR, or when FIFO count >= DEPTH-2, and 0 otherwise. It drops in the cycle after CLEAR exits.
- Counter and address arithmetic is unsigned. The clear counter never exceeds NPIX-1.

Optional Feature:
- Macro FBUF_WRITE_BRIDGE_STATS_EN.
- When defined: drop_count increments by 1 on each write dropped for FIFO-full or out-of-range. It saturates at 16'hFFFF and clears only on rst. Writes discarded in DRAIN/CLEAR are not counted.
- When undefined: drop_count is tied to 0 and no counter logic is built.

Test Plan:
- W=4, H=2, DEPTH=4, bram_gnt=1; write addr 3, data 8'h5A -> bram_en=1, addr=3, din=8'h5A exactly 2 cycles after acceptance; fbuf_rst_busy stays 0.
- bram_gnt=0; 4 writes then a 5th -> 5th dropped (drop_count=1 with STATS_EN); busy=1 from count 2. Raise gnt -> 4 writes leave in order.
- Write addr 8 (NPIX=8) -> no bram_en; drop_count=1 with STATS_EN, 0 without.
- 2 queued writes, then pulse fbuf_rst_req_n low -> both queued writes issue, then addr 0..7 with din=CLEAR_VALUE. Busy high throughout and drops 1 cycle after addr 7. Writes offered meanwhile never appear.
- Toggle bram_gnt 1/0 during CLEAR -> addresses are contiguous with no skips or duplicates; 8 writes total.
- Assert rst at clear address 3 -> bram_en=0 and busy=0 next cycle, state IDLE; a new write issues normally.

Source files
------------

// File: rtl/fbuf_write_bridge.sv
// Framebuffer write bridge: FIFO-buffers decoder pixel writes onto a shared BRAM port A and runs framebuffer clears.
// Optional dropped-write counter enabled by defining FBUF_WRITE_BRIDGE_STATS_EN.
module fbuf_write_bridge #(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int FBUF_ADDR_WIDTH     = 19,
  parameter int FBUF_DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH_LOG2     = 4,
  parameter logic [FBUF_DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fbuf_en_wr,
  input  logic                       fbuf_wrea,
  input  logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  input  logic                       fbuf_rst_req_n,
  output logic                       fbuf_rst_busy,
  input  logic                       bram_gnt,
  output logic                       bram_en,
  output logic                       bram_we,
  output logic [FBUF_ADDR_WIDTH-1:0] bram_addr,
  output logic [FBUF_DATA_WIDTH-1:0] bram_din,
  output logic [15:0]                drop_count
);

  localparam int AW    = FBUF_ADDR_WIDTH;
  localparam int DW    = FBUF_DATA_WIDTH;
  localparam int NPIX  = FRAME_WIDTH_SCALED * FRAME_HEIGHT_SCALED;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [AW:0]   NPIX_EXT  = (AW+1)'(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_FULL = CW'(DEPTH - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  state_t                     state_reg, state_next;
  logic [AW+DW-1:0]           fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]              count_reg;
  logic [AW-1:0]              clr_cnt_reg, clr_cnt_next;
  logic                       req_prev_reg;
  logic                       bram_en_reg, busy_reg;
  logic [AW-1:0]              bram_addr_reg;
  logic [DW-1:0]              bram_din_reg;

  logic offered, in_range, fifo_empty, fifo_full, pop, push, clear_fall, clr_issue;

  assign offered    = fbuf_en_wr & fbuf_wrea;
  assign in_range   = {1'b0, fbuf_addr} < NPIX_EXT;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_C);
  assign pop        = bram_gnt && !fifo_empty && (state_reg != ST_CLEAR);
  // A full FIFO still accepts when the head leaves on the same edge
  assign push       = (state_reg == ST_IDLE) && offered && in_range && (!fifo_full || pop);
  assign clear_fall = req_prev_reg && !fbuf_rst_req_n;
  assign clr_issue  = (state_reg == ST_CLEAR) && bram_gnt;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clear_fall) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      ST_CLEAR: begin
        if (bram_gnt) begin
          if (clr_cnt_reg == LAST_ADDR) state_next = ST_IDLE;
          else clr_cnt_next = clr_cnt_reg + AW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {fbuf_addr, fbuf_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      clr_cnt_reg   <= '0;
      req_prev_reg  <= 1'b1;
      bram_en_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      req_prev_reg <= fbuf_rst_req_n;
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // Address/data hold their last values whenever nothing is issued
      if (pop) begin
        bram_en_reg                   <= 1'b1;
        {bram_addr_reg, bram_din_reg} <= fifo_mem[rd_ptr_reg];
      end else if (clr_issue) begin
        bram_en_reg   <= 1'b1;
        bram_addr_reg <= clr_cnt_reg;
        bram_din_reg  <= CLEAR_VALUE;
      end else begin
        bram_en_reg <= 1'b0;
      end
      busy_reg <= (state_reg != ST_IDLE) || (count_reg >= NEAR_FULL);
    end
  end

  assign bram_en       = bram_en_reg;
  assign bram_we       = bram_en_reg;
  assign bram_addr     = bram_addr_reg;
  assign bram_din      = bram_din_reg;
  assign fbuf_rst_busy = busy_reg;

`ifdef FBUF_WRITE_BRIDGE_STATS_EN
  logic        drop;
  logic [15:0] drop_cnt_reg;

  // Discards during DRAIN/CLEAR are intentional and not counted
  assign drop = (state_reg == ST_IDLE) && offered && (!in_range || (fifo_full && !pop));

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_reg <= '0;
    else if (drop && (drop_cnt_reg != 16'hFFFF)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end

  assign drop_count = drop_cnt_reg;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fbuf_write_bridge.sv
// Scoreboard bench for fbuf_write_bridge on a 4x2 frame with a 4-deep FIFO.
module tb_fbuf_write_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n, bram_gnt;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;
  logic        fbuf_rst_busy, bram_en, bram_we;
  logic [18:0] bram_addr;
  logic [7:0]  bram_din;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int exp_drops = 0;
  logic [18:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];

  fbuf_write_bridge #(
    .FRAME_WIDTH_SCALED(4), .FRAME_HEIGHT_SCALED(2), .FBUF_ADDR_WIDTH(19),
    .FBUF_DATA_WIDTH(8), .FIFO_DEPTH_LOG2(2), .CLEAR_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea),
    .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data), .fbuf_rst_req_n(fbuf_rst_req_n),
    .fbuf_rst_busy(fbuf_rst_busy), .bram_gnt(bram_gnt), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int stat_drops(input int n);
`ifdef FBUF_WRITE_BRIDGE_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic expect_wr(input logic [18:0] a, input logic [7:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [18:0] a, input logic [7:0] d, input bit accept);
    fbuf_en_wr = 1'b1; fbuf_wrea = 1'b1; fbuf_addr = a; fbuf_data = d;
    if (accept) expect_wr(a, d);
    tick();
    fbuf_en_wr = 1'b0; fbuf_wrea = 1'b0;
  endtask

  task automatic pulse_clear();
    fbuf_rst_req_n = 1'b0;
    tick();
    fbuf_rst_req_n = 1'b1;
  endtask

  // Every issued BRAM write must match the head of the expected queue
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (bram_en) begin
        $display("bram write addr=%0d din=%02h we=%0b", bram_addr, bram_din, bram_we);
        chk("bram_we_eq_en", {31'd0, bram_we}, 32'd1);
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_write_addr", {13'd0, bram_addr}, 32'hFFFF_FFFF);
        end else begin
          chk("wr_addr", {13'd0, bram_addr}, {13'd0, exp_addr_q.pop_front()});
          chk("wr_data", {24'd0, bram_din}, {24'd0, exp_data_q.pop_front()});
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    rst = 1'b1; fbuf_en_wr = 1'b0; fbuf_wrea = 1'b0; fbuf_addr = '0; fbuf_data = '0;
    fbuf_rst_req_n = 1'b1; bram_gnt = 1'b0;
    tick(); tick();
    chk("rst_bram_en", {31'd0, bram_en}, 32'd0);
    chk("rst_bram_addr", {13'd0, bram_addr}, 32'd0);
    chk("rst_bram_din", {24'd0, bram_din}, 32'd0);
    chk("rst_busy", {31'd0, fbuf_rst_busy}, 32'd0);
    chk("rst_drops", {16'd0, drop_count}, 32'd0);
    rst = 1'b0;
    bram_gnt = 1'b1;
    tick();

    // Single write, two-edge latency
    wr(19'd3, 8'h5A, 1'b1);
    chk("lat_en_early", {31'd0, bram_en}, 32'd0);
    tick();
    chk("lat_en", {31'd0, bram_en}, 32'd1);
    chk("lat_addr", {13'd0, bram_addr}, 32'd3);
    chk("lat_din", {24'd0, bram_din}, 32'h5A);
    chk("lat_busy", {31'd0, fbuf_rst_busy}, 32'd0);

    // Fill with grant low, overflow one, then drain in order
    bram_gnt = 1'b0;
    tick();
    wr(19'd1, 8'h11, 1'b1);
    chk("fill1_busy", {31'd0, fbuf_rst_busy}, 32'd0);
    wr(19'd2, 8'h12, 1'b1);
    chk("fill2_busy", {31'd0, fbuf_rst_busy}, 32'd0);
    wr(19'd4, 8'h13, 1'b1);
    chk("fill3_busy", {31'd0, fbuf_rst_busy}, 32'd1);
    wr(19'd5, 8'h14, 1'b1);
    wr(19'd6, 8'h15, 1'b0);
    exp_drops++;
    chk("full_busy", {31'd0, fbuf_rst_busy}, 32'd1);
    chk("full_drops", {16'd0, drop_count}, stat_drops(exp_drops));
    chk("full_no_issue", {31'd0, bram_en}, 32'd0);
    bram_gnt = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("fill_drained", exp_addr_q.size(), 32'd0);
    chk("fill_busy_low", {31'd0, fbuf_rst_busy}, 32'd0);

    // Out-of-range address
    wr(19'd8, 8'h99, 1'b0);
    exp_drops++;
    for (int i = 0; i < 3; i++) tick();
    chk("oor_drops", {16'd0, drop_count}, stat_drops(exp_drops));
    chk("oor_no_issue", exp_addr_q.size(), 32'd0);

    // Clear with two queued writes and writes offered during drain/clear
    bram_gnt = 1'b0;
    wr(19'd2, 8'hA1, 1'b1);
    wr(19'd7, 8'hA2, 1'b1);
    pulse_clear();
    bram_gnt = 1'b1;
    for (int a = 0; a < 8; a++) expect_wr(19'(a), 8'h00);
    for (int i = 1; i <= 11; i++) begin
      fbuf_en_wr = (i <= 4); fbuf_wrea = (i <= 4); fbuf_addr = 19'd1; fbuf_data = 8'h77;
      tick();
      chk("clr_busy", {31'd0, fbuf_rst_busy}, 32'd1);
    end
    fbuf_en_wr = 1'b0; fbuf_wrea = 1'b0;
    chk("clr_last_en", {31'd0, bram_en}, 32'd1);
    chk("clr_last_addr", {13'd0, bram_addr}, 32'd7);
    chk("clr_last_din", {24'd0, bram_din}, 32'd0);
    tick();
    chk("clr_busy_drop", {31'd0, fbuf_rst_busy}, 32'd0);
    chk("clr_idle_en", {31'd0, bram_en}, 32'd0);
    chk("clr_done", exp_addr_q.size(), 32'd0);
    chk("clr_drops", {16'd0, drop_count}, stat_drops(exp_drops));

    // Grant toggling during clear, request held low throughout
    fbuf_rst_req_n = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) expect_wr(19'(a), 8'h00);
    for (int i = 0; i < 40 && exp_addr_q.size() != 0; i++) begin
      bram_gnt = i[0];
      tick();
    end
    chk("toggle_done", exp_addr_q.size(), 32'd0);
    bram_gnt = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("toggle_busy_low", {31'd0, fbuf_rst_busy}, 32'd0);
    chk("hold_no_retrigger", {31'd0, bram_en}, 32'd0);
    fbuf_rst_req_n = 1'b1;
    tick();

    // Reset in the middle of a clear
    pulse_clear();
    for (int a = 0; a < 4; a++) expect_wr(19'(a), 8'h00);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_clr_en", {31'd0, bram_en}, 32'd1);
    chk("mid_clr_addr", {13'd0, bram_addr}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_drops = 0;
    chk("abort_en", {31'd0, bram_en}, 32'd0);
    chk("abort_busy", {31'd0, fbuf_rst_busy}, 32'd0);
    chk("abort_drops", {16'd0, drop_count}, 32'd0);
    chk("abort_queue", exp_addr_q.size(), 32'd0);
    wr(19'd6, 8'hC3, 1'b1);
    tick();
    chk("post_rst_en", {31'd0, bram_en}, 32'd1);
    chk("post_rst_addr", {13'd0, bram_addr}, 32'd6);
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_done", exp_addr_q.size(), 32'd0);
    chk("post_rst_busy", {31'd0, fbuf_rst_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
